// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: IF stage with word-addressed PC, one outstanding imem read,
// a small prefetch queue feeding IF/ID, redirect/stall handling and halt on terminate word.
module instruction_fetch_unit #(
  parameter int          QDEPTH    = 2,
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc_inc,
  output logic        halted
);
  localparam int AW = $clog2(QDEPTH);
  typedef enum logic [1:0] {FETCH, WAIT, HALT} state_t;
  state_t        r_state, w_next;
  logic [31:0]   r_pc;
  logic          r_squash;
  logic [31:0]   r_q_instr [QDEPTH];
  logic [31:0]   r_q_pcinc [QDEPTH];
  logic [AW-1:0] r_rd, r_wr;
  logic [AW:0]   r_count;
  logic [AW+1:0] w_level;
  logic          w_resp, w_push, w_pop, w_free;
  assign w_resp     = (r_state == WAIT) & imem_rvalid;
  assign w_push     = w_resp & ~r_squash & ~redirect_valid;
  assign w_pop      = ifid_valid & ~stall & ~redirect_valid;
  assign w_level    = {1'b0, r_count} + (AW+2)'(w_push) - (AW+2)'(w_pop);
  assign w_free     = w_level < (AW+2)'(QDEPTH);
  // A non-halt response may chain straight into the next request for 1 instr/cycle.
  assign imem_req   = ~reset & ~redirect_valid & w_free &
                      ((r_state == FETCH) | (w_push & (imem_rdata != HALT_WORD)));
  assign imem_addr  = r_pc;
  assign ifid_valid = r_count != '0;
  assign ifid_instr = ifid_valid ? r_q_instr[r_rd] : '0;
  assign ifid_pc_inc = ifid_valid ? r_q_pcinc[r_rd] : '0;
  assign halted     = r_state == HALT;
  always_comb begin
    w_next = redirect_valid ? ((r_state == WAIT && !imem_rvalid) ? WAIT : FETCH) :
             imem_req       ? WAIT :
             w_resp         ? ((w_push && imem_rdata == HALT_WORD) ? HALT : FETCH) :
                              r_state;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= FETCH;
    else       r_state <= w_next;
  end
  // While WAIT, r_pc already equals request address + 1, so it is the pushed pc_inc.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc     <= RESET_PC;
      r_squash <= 1'b0;
      r_rd     <= '0;
      r_wr     <= '0;
      r_count  <= '0;
    end else begin
      r_pc     <= redirect_valid ? redirect_pc : imem_req ? r_pc + 32'd1 : r_pc;
      r_squash <= redirect_valid ? (r_state == WAIT && !imem_rvalid) : (w_resp ? 1'b0 : r_squash);
      r_rd     <= redirect_valid ? '0 : r_rd + AW'(w_pop);
      r_wr     <= redirect_valid ? '0 : r_wr + AW'(w_push);
      r_count  <= redirect_valid ? '0 : r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_instr[r_wr] <= imem_rdata;
      r_q_pcinc[r_wr] <= r_pc;
    end
  end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed checks of the fetch unit against a
// variable-latency instruction RAM model.
module tb_instruction_fetch_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_inc;
  logic        halted;
  int tests = 0;
  int fails = 0;
  int lat = 1;
  int mcnt;
  logic [31:0] maddr;
  logic [31:0] mem [128];
  instruction_fetch_unit dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
    .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc_inc(ifid_pc_inc),
    .halted(halted)
  );
  always #5 clk = ~clk;
  // RAM model: response arrives lat cycles after the accepting edge, in order.
  always @(posedge clk or posedge reset) begin
    if (reset) mcnt <= 0;
    else if (imem_req) begin
      mcnt  <= lat;
      maddr <= imem_addr;
    end else if (mcnt != 0) mcnt <= mcnt - 1;
  end
  assign imem_rvalid = mcnt == 1;
  assign imem_rdata  = mem[maddr[6:0]];
  typedef struct {
    logic        stall;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pcinc;
    logic        req;
    logic [31:0] addr;
  } vec_t;
  vec_t vecs [15];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic reset_dut();
    reset = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic wait_valid(input string name);
    int n = 0;
    while (!ifid_valid && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(name, 32'(ifid_valid), 32'd1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'h10 + 32'(i);
    vecs[0]  = '{1'b0, 1'b0, 32'h00, 32'd0, 1'b1, 32'd0};
    vecs[1]  = '{1'b0, 1'b0, 32'h00, 32'd0, 1'b1, 32'd1};
    vecs[2]  = '{1'b0, 1'b1, 32'h10, 32'd1, 1'b1, 32'd2};
    vecs[3]  = '{1'b0, 1'b1, 32'h11, 32'd2, 1'b1, 32'd3};
    vecs[4]  = '{1'b0, 1'b1, 32'h12, 32'd3, 1'b1, 32'd4};
    vecs[5]  = '{1'b1, 1'b1, 32'h13, 32'd4, 1'b0, 32'd5};
    vecs[6]  = '{1'b1, 1'b1, 32'h13, 32'd4, 1'b0, 32'd5};
    vecs[7]  = '{1'b1, 1'b1, 32'h13, 32'd4, 1'b0, 32'd5};
    vecs[8]  = '{1'b1, 1'b1, 32'h13, 32'd4, 1'b0, 32'd5};
    vecs[9]  = '{1'b1, 1'b1, 32'h13, 32'd4, 1'b0, 32'd5};
    vecs[10] = '{1'b0, 1'b1, 32'h13, 32'd4, 1'b1, 32'd5};
    vecs[11] = '{1'b0, 1'b1, 32'h14, 32'd5, 1'b1, 32'd6};
    vecs[12] = '{1'b0, 1'b1, 32'h15, 32'd6, 1'b1, 32'd7};
    vecs[13] = '{1'b0, 1'b1, 32'h16, 32'd7, 1'b1, 32'd8};
    vecs[14] = '{1'b0, 1'b1, 32'h17, 32'd8, 1'b1, 32'd9};
    // reset values
    reset = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(ifid_valid), 32'd0);
    chk("rst_instr", ifid_instr, 32'd0);
    chk("rst_pcinc", ifid_pc_inc, 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    // streaming with a stall window, latency-1 RAM
    lat = 1;
    reset_dut();
    for (int i = 0; i < 15; i++) begin
      if (i > 0) @(negedge clk);
      stall = vecs[i].stall;
      #1;
      chk($sformatf("vec%0d_valid", i), 32'(ifid_valid), 32'(vecs[i].valid));
      if (vecs[i].valid) begin
        chk($sformatf("vec%0d_instr", i), ifid_instr, vecs[i].instr);
        chk($sformatf("vec%0d_pcinc", i), ifid_pc_inc, vecs[i].pcinc);
      end
      chk($sformatf("vec%0d_req", i), 32'(imem_req), 32'(vecs[i].req));
      chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].addr);
      chk($sformatf("vec%0d_halted", i), 32'(halted), 32'd0);
    end
    // redirect while waiting on a 3-cycle RAM
    lat = 3;
    reset_dut();
    #1;
    chk("rd_c0_req", 32'(imem_req), 32'd1);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    #1;
    chk("rd_c1_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    chk("rd_c2_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    #1;
    chk("rd_c3_late_rvalid", 32'(imem_rvalid), 32'd1);
    chk("rd_c3_req", 32'(imem_req), 32'd0);
    chk("rd_c3_valid", 32'(ifid_valid), 32'd0);
    @(negedge clk);
    #1;
    chk("rd_c4_req", 32'(imem_req), 32'd1);
    chk("rd_c4_addr", imem_addr, 32'h40);
    wait_valid("rd_valid");
    chk("rd_instr", ifid_instr, 32'h50);
    chk("rd_pcinc", ifid_pc_inc, 32'h41);
    // halt word at address 5
    mem[5] = 32'hFFFF_FFFF;
    lat = 1;
    reset_dut();
    for (int n = 0; n < 20 && !(ifid_valid && ifid_pc_inc == 32'd6); n++) begin
      @(negedge clk);
      #1;
    end
    chk("halt_instr", ifid_instr, 32'hFFFF_FFFF);
    chk("halt_pcinc", ifid_pc_inc, 32'd6);
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_req", 32'(imem_req), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("halt_hold%0d_req", i), 32'(imem_req), 32'd0);
      chk($sformatf("halt_hold%0d_halted", i), 32'(halted), 32'd1);
      chk($sformatf("halt_hold%0d_valid", i), 32'(ifid_valid), 32'd0);
    end
    // redirect out of HALT
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'd2;
    #1;
    chk("rh_req_during", 32'(imem_req), 32'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    chk("rh_halted", 32'(halted), 32'd0);
    chk("rh_req", 32'(imem_req), 32'd1);
    chk("rh_addr", imem_addr, 32'd2);
    wait_valid("rh_valid");
    chk("rh_instr", ifid_instr, 32'h12);
    chk("rh_pcinc", ifid_pc_inc, 32'd3);
    // reset in the middle of WAIT
    mem[5] = 32'h15;
    lat = 3;
    reset_dut();
    #1;
    chk("mr_c0_req", 32'(imem_req), 32'd1);
    @(negedge clk);
    #1;
    chk("mr_wait_req", 32'(imem_req), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mr_req", 32'(imem_req), 32'd0);
    chk("mr_valid", 32'(ifid_valid), 32'd0);
    chk("mr_instr", ifid_instr, 32'd0);
    chk("mr_pcinc", ifid_pc_inc, 32'd0);
    chk("mr_halted", 32'(halted), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mr_first_req", 32'(imem_req), 32'd1);
    chk("mr_first_addr", imem_addr, 32'd0);
    wait_valid("mr_valid_after");
    chk("mr_instr_after", ifid_instr, 32'h10);
    chk("mr_pcinc_after", ifid_pc_inc, 32'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
